// File: rtl/sv_matmul_ctrl_pkg.sv
// Shared attention package: default dimensions and the matmul controller state encoding.
package sv_matmul_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_TOKEN_DIM  = 4;
  localparam int DEF_TOKEN_NUM  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dff.sv
// Generic enabled D flip-flop bank with asynchronous active-low clear.
module dff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/sv_matmul_ctrl_row_buffer.sv
// Output token buffer: one dff bank per row, written one row at a time, read as a full matrix.
module sv_row_buffer
  import sv_matmul_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TOKEN_DIM  = DEF_TOKEN_DIM,
  parameter int TOKEN_NUM  = DEF_TOKEN_NUM,
  parameter int IDX_W      = $clog2(TOKEN_NUM + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  wr_en,
  input  logic [IDX_W-1:0]                      wr_idx,
  input  logic [DATA_WIDTH*TOKEN_DIM-1:0]       wr_data,
  output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] rd_data
);

  localparam int ROW_W = DATA_WIDTH * TOKEN_DIM;

  for (genvar r = 0; r < TOKEN_NUM; r++) begin : g_row
    dff #(.WIDTH(ROW_W)) u_row (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (wr_en && (wr_idx == IDX_W'(r))),
      .d     (wr_data),
      .q     (rd_data[r*ROW_W +: ROW_W])
    );
  end

endmodule

// File: rtl/sv_matmul_ctrl.sv
// Sequences S*V through a shared row unit: issues one S row per cycle, collects result rows, hands off the matrix.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for a job; in_ready high
// ST_ISSUE | issuing S rows 0..TOKEN_NUM-1, collecting any early results
// ST_DRAIN | all rows issued; collecting remaining results
// ST_DONE  | token_out complete; out_valid held until out_ready
module sv_matmul_ctrl
  import sv_matmul_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int TOKEN_DIM   = DEF_TOKEN_DIM,
  parameter int TOKEN_NUM   = DEF_TOKEN_NUM,
  parameter int MUL_LATENCY = 2
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [DATA_WIDTH*TOKEN_NUM*TOKEN_NUM-1:0] S_in,
  input  logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] V_in,
  output logic                                      mul_issue,
  output logic [DATA_WIDTH*TOKEN_NUM-1:0]           mul_row,
  output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] mul_V,
  input  logic [DATA_WIDTH*TOKEN_DIM-1:0]           mul_result,
  input  logic                                      mul_result_valid,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] token_out,
  output logic                                      busy
);

  localparam int ROW_IN_W = DATA_WIDTH * TOKEN_NUM;
  localparam int CNT_W    = $clog2(TOKEN_NUM + 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(TOKEN_NUM - 1);
  localparam logic [CNT_W-1:0] ROWS     = CNT_W'(TOKEN_NUM);

  if (MUL_LATENCY < 0) begin : g_bad_latency
    $error("sv_matmul_ctrl: MUL_LATENCY must be non-negative");
  end

  state_t state, state_nxt;

  logic [CNT_W-1:0]                          issue_cnt;
  logic [CNT_W-1:0]                          wr_cnt;
  logic [DATA_WIDTH*TOKEN_NUM*TOKEN_NUM-1:0] s_reg;
  logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] v_reg;
  logic                                      accept;
  logic                                      wr_fire;
  logic                                      last_write;
  logic                                      last_issue;

  assign accept     = in_valid && in_ready;
  assign wr_fire    = mul_result_valid && ((state == ST_ISSUE) || (state == ST_DRAIN))
                      && (wr_cnt < ROWS);
  assign last_write = wr_fire && (wr_cnt == LAST_ROW);
  assign last_issue = (issue_cnt == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // The final write wins over the last issue so a zero-latency unit skips DRAIN.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (in_valid) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (last_write)      state_nxt = ST_DONE;
        else if (last_issue) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (last_write) state_nxt = ST_DONE;
      ST_DONE:  if (out_ready)  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    mul_issue = (state == ST_ISSUE);
    out_valid = (state == ST_DONE);
    busy      = (state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg     <= '0;
      v_reg     <= '0;
      issue_cnt <= '0;
      wr_cnt    <= '0;
    end else if (accept) begin
      s_reg     <= S_in;
      v_reg     <= V_in;
      issue_cnt <= '0;
      wr_cnt    <= '0;
    end else begin
      if (mul_issue) issue_cnt <= issue_cnt + CNT_W'(1);
      if (wr_fire)   wr_cnt    <= wr_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    mul_row = '0;
    if (state == ST_ISSUE) begin
      for (int r = 0; r < TOKEN_NUM; r++) begin
        if (issue_cnt == CNT_W'(r)) mul_row = s_reg[r*ROW_IN_W +: ROW_IN_W];
      end
    end
  end

  assign mul_V = v_reg;

  sv_row_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .TOKEN_DIM  (TOKEN_DIM),
    .TOKEN_NUM  (TOKEN_NUM),
    .IDX_W      (CNT_W)
  ) u_row_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_fire),
    .wr_idx  (wr_cnt),
    .wr_data (mul_result),
    .rd_data (token_out)
  );

endmodule

// File: tb/tb_sv_matmul_ctrl.sv
// Directed/random bench for sv_matmul_ctrl with a behavioural row unit and matrix-product reference.
module tb_sv_matmul_ctrl;

  localparam int DW  = 16;
  localparam int TD  = 4;
  localparam int TN  = 8;
  localparam int LAT = 2;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [DW*TN*TN-1:0]  S_in;
  logic [DW*TD*TN-1:0]  V_in;
  logic                 mul_issue;
  logic [DW*TN-1:0]     mul_row;
  logic [DW*TD*TN-1:0]  mul_V;
  logic [DW*TD-1:0]     mul_result;
  logic                 mul_result_valid;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW*TD*TN-1:0]  token_out;
  logic                 busy;

  sv_matmul_ctrl #(
    .DATA_WIDTH  (DW),
    .TOKEN_DIM   (TD),
    .TOKEN_NUM   (TN),
    .MUL_LATENCY (LAT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .S_in             (S_in),
    .V_in             (V_in),
    .mul_issue        (mul_issue),
    .mul_row          (mul_row),
    .mul_V            (mul_V),
    .mul_result       (mul_result),
    .mul_result_valid (mul_result_valid),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .token_out        (token_out),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference job data
  logic [15:0]         s_m [TN][TN];
  logic [15:0]         v_m [TN][TD];
  logic [DW*TD*TN-1:0] exp_tok;

  // behavioural row unit
  typedef struct {
    int               due;
    logic [DW*TD-1:0] data;
  } res_t;

  res_t q[$];
  int   cyc          = 0;
  int   issue_idx    = 0;
  int   n_issued     = 0;
  int   n_delivered  = 0;
  int   last_res_cyc = 0;
  int   extra_all    = 0;
  int   extra_last   = 0;
  int   junk_cnt     = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      issue_idx = 0;
    end else if (mul_issue) begin
      res_t e;
      for (int c = 0; c < TD; c++) begin
        logic [15:0] acc;
        acc = '0;
        for (int k = 0; k < TN; k++)
          acc = acc + mul_row[k*DW +: DW] * mul_V[(k*TD + c)*DW +: DW];
        e.data[c*DW +: DW] = acc;
      end
      e.due = cyc + LAT + extra_all + ((issue_idx == TN-1) ? extra_last : 0);
      q.push_back(e);
      issue_idx = (issue_idx == TN-1) ? 0 : issue_idx + 1;
      n_issued++;
    end
    cyc++;
  end

  always @(negedge clk) begin
    mul_result_valid = 1'b0;
    mul_result       = '0;
    if (q.size() > 0 && q[0].due <= cyc) begin
      res_t e;
      e = q.pop_front();
      mul_result_valid = 1'b1;
      mul_result       = e.data;
      n_delivered++;
      last_res_cyc = cyc;
    end else if (junk_cnt > 0) begin
      mul_result_valid = 1'b1;
      mul_result       = {$urandom, $urandom};
      junk_cnt--;
    end
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_job(input bit ident);
    for (int r = 0; r < TN; r++) begin
      for (int k = 0; k < TN; k++) begin
        s_m[r][k] = ident ? ((r == k) ? 16'd1 : 16'd0) : 16'($urandom_range(0, 65535));
        S_in[(r*TN + k)*DW +: DW] = s_m[r][k];
      end
      for (int c = 0; c < TD; c++) begin
        v_m[r][c] = ident ? 16'(r + 1) : 16'($urandom_range(0, 65535));
        V_in[(r*TD + c)*DW +: DW] = v_m[r][c];
      end
    end
    for (int r = 0; r < TN; r++)
      for (int c = 0; c < TD; c++) begin
        logic [15:0] acc;
        acc = '0;
        for (int k = 0; k < TN; k++) acc = acc + s_m[r][k] * v_m[k][c];
        exp_tok[(r*TD + c)*DW +: DW] = acc;
      end
  endtask

  task automatic wait_out(input string tag);
    int t;
    t = 0;
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_out_valid_seen"}, 512'(out_valid), 512'(1));
  endtask

  task automatic run_job(input string tag, input int xa, input int xl, input int hold, input int exp_lat);
    int acc_cyc;
    int iss0;
    logic [DW*TN-1:0] row0;
    for (int k = 0; k < TN; k++) row0[k*DW +: DW] = s_m[0][k];
    @(negedge clk);
    extra_all  = xa;
    extra_last = xl;
    out_ready  = (hold == 0);
    in_valid   = 1'b1;
    iss0       = n_issued;
    check({tag, "_in_ready"}, 512'(in_ready), 512'(1));
    acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_mul_V"}, 512'(mul_V), 512'(V_in));
    check({tag, "_issue_row0"}, 512'({mul_issue, mul_row}), 512'({1'b1, row0}));
    wait_out(tag);
    check({tag, "_latency"}, 512'(cyc - acc_cyc), 512'(exp_lat));
    check({tag, "_token"}, 512'(token_out), 512'(exp_tok));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 512'({out_valid, in_ready}), 512'({1'b1, 1'b0}));
      check({tag, "_hold_token"}, 512'(token_out), 512'(exp_tok));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_back_idle"}, 512'({out_valid, in_ready, busy}), 512'({1'b0, 1'b1, 1'b0}));
    check({tag, "_token_kept"}, 512'(token_out), 512'(exp_tok));
    check({tag, "_rows_issued"}, 512'(n_issued - iss0), 512'(TN));
    extra_all  = 0;
    extra_last = 0;
  endtask

  initial begin
    logic [DW*TD*TN-1:0] exp_a;
    int                  acc_b;
    int                  t;
    int                  base;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    S_in      = '0;
    V_in      = '0;
    repeat (3) @(negedge clk);
    check("reset_flags", 512'({in_ready, mul_issue, out_valid, busy}), 512'(4'b1000));
    check("reset_token", 512'(token_out), 512'(0));
    check("reset_mul_V", 512'(mul_V), 512'(0));
    check("reset_mul_row", 512'(mul_row), 512'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // identity S, V rows 1..8: result equals V, out_valid at cycle 11
    load_job(1'b1);
    check("ident_model", 512'(exp_tok), 512'(V_in));
    run_job("ident", 0, 0, 0, TN + LAT + 1);

    // consumer stalls 5 cycles in DONE
    load_job(1'b0);
    run_job("stall", 0, 0, 5, TN + LAT + 1);

    // spurious results while idle must not land in the buffer
    @(negedge clk);
    junk_cnt = 3;
    repeat (5) @(negedge clk);
    check("junk_idle", 512'({in_ready, busy}), 512'({1'b1, 1'b0}));
    load_job(1'b0);
    run_job("after_junk", 0, 0, 0, TN + LAT + 1);

    // reset in DRAIN after four results have been written
    load_job(1'b0);
    @(negedge clk);
    extra_all = 4;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    base      = n_delivered;
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (n_delivered < base + 4 && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("rst_four_results", 512'(n_delivered - base), 512'(4));
    #1;
    check("pre_rst_busy", 512'({busy, mul_issue}), 512'({1'b1, 1'b0}));
    rst_n = 1'b0;
    #1;
    check("midrst_flags", 512'({in_ready, mul_issue, out_valid, busy}), 512'(4'b1000));
    check("midrst_token", 512'(token_out), 512'(0));
    check("midrst_mul_V", 512'(mul_V), 512'(0));
    @(negedge clk);
    rst_n     = 1'b1;
    extra_all = 0;
    repeat (15) @(negedge clk);
    check("stale_ignored", 512'({token_out, in_ready}), 512'({512'(0), 1'b1}));
    load_job(1'b0);
    run_job("post_rst", 0, 0, 0, TN + LAT + 1);

    // back-to-back in_valid held high
    load_job(1'b0);
    exp_a = exp_tok;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    check("b2b_a_ready", 512'(in_ready), 512'(1));
    base = cyc;
    @(negedge clk);
    load_job(1'b0);
    t = 0;
    while (!out_valid && t < 100) begin
      check("b2b_a_busy_not_ready", 512'(in_ready), 512'(0));
      @(negedge clk);
      t++;
    end
    check("b2b_a_valid", 512'(out_valid), 512'(1));
    check("b2b_a_latency", 512'(cyc - base), 512'(TN + LAT + 1));
    check("b2b_a_token", 512'(token_out), 512'(exp_a));
    @(negedge clk);
    check("b2b_idle_gap", 512'({in_ready, out_valid}), 512'({1'b1, 1'b0}));
    acc_b = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_b_not_ready", 512'(in_ready), 512'(0));
    wait_out("b2b_b");
    check("b2b_b_latency", 512'(cyc - acc_b), 512'(TN + LAT + 1));
    check("b2b_b_token", 512'(token_out), 512'(exp_tok));
    @(negedge clk);

    // last result delayed 3 extra cycles
    load_job(1'b0);
    run_job("late_last", 0, 3, 0, TN + LAT + 1 + 3);

    @(negedge clk);
    load_job(1'b0);
    extra_last = 3;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out("late_edge");
    check("late_edge_one_after", 512'(cyc - last_res_cyc), 512'(1));
    check("late_edge_token", 512'(token_out), 512'(exp_tok));
    extra_last = 0;
    @(negedge clk);

    // a few more random jobs with random consumer stalls
    for (int j = 0; j < 3; j++) begin
      load_job(1'b0);
      run_job("rand", 0, 0, $urandom_range(0, 3), TN + LAT + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
